// File: rtl/rc4_pkg.sv
// Shared RC4 constants and the key-scheduling FSM state encoding.
package rc4_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int S_SIZE = 256;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    NEXT,
    DONE
  } ksa_state_t;
endpackage

// File: rtl/ksa_swap_fsm_if.sv
// Start/key handshake plus single-port S RAM bus of the KSA stage; master = the FSM.
interface ksa_swap_fsm_if #(
  parameter int KEY_BYTES = 3
);
  import rc4_pkg::*;

  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [DATA_W-1:0]      q;
  logic [ADDR_W-1:0]      address_out;
  logic [DATA_W-1:0]      data_out;
  logic                   write_out;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, secret_key, q,
    output address_out, data_out, write_out, busy, done
  );

  modport slave (
    output start, secret_key, q,
    input  address_out, data_out, write_out, busy, done
  );
endinterface

// File: rtl/ksa_key_byte_sel.sv
// Selects key byte k from the registered key, byte 0 being the most significant.
module ksa_key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int K_W       = 2
) (
  input  logic [8*KEY_BYTES-1:0] key_r,
  input  logic [K_W-1:0]         k,
  output logic [7:0]             key_byte
);
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == K_W'(b)) key_byte = key_r[8*(KEY_BYTES-1-b) +: 8];
    end
  end
endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 key schedule over the S RAM: 256 iterations of 5+2*READ_LATENCY cycles, done is sticky.
// KSA_SKIP_SELF_SWAP_EN: iterations with i==j skip both writes and go straight to NEXT.
module ksa_swap_fsm
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES    = 3,
  parameter int READ_LATENCY = 1
) (
  input logic            clk,
  input logic            master_reset,
  ksa_swap_fsm_if.master bus
);
  localparam int K_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(S_SIZE - 1);

  ksa_state_t             state_q, state_d;
  logic [ADDR_W-1:0]      i_q, j_q;
  logic [K_W-1:0]         k_q;
  logic [DATA_W-1:0]      s_i_q, s_j_q;
  logic [8*KEY_BYTES-1:0] key_r;
  logic [LAT_W-1:0]       lat_q;
  logic                   lat_last;
  logic [7:0]             key_byte;

  assign lat_last = (lat_q == LAT_LAST);

  ksa_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (K_W)
  ) u_key_sel (
    .key_r    (key_r),
    .k        (k_q),
    .key_byte (key_byte)
  );

  always_ff @(posedge clk or negedge master_reset) begin
    if (!master_reset) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.address_out = j_q;
    bus.data_out    = '0;
    bus.write_out   = 1'b0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = READ_I;
      end
      READ_I: begin
        bus.address_out = i_q;
        state_d         = WAIT_I;
      end
      WAIT_I: if (lat_last) state_d = READ_J;
      READ_J: state_d = WAIT_J;
      WAIT_J: begin
        if (lat_last) begin
`ifdef KSA_SKIP_SELF_SWAP_EN
          state_d = (i_q == j_q) ? NEXT : WRITE_I;
`else
          state_d = WRITE_I;
`endif
        end
      end
      WRITE_I: begin
        bus.address_out = i_q;
        bus.data_out    = s_j_q;
        bus.write_out   = 1'b1;
        state_d         = WRITE_J;
      end
      WRITE_J: begin
        bus.data_out  = s_i_q;
        bus.write_out = 1'b1;
        state_d       = NEXT;
      end
      NEXT: state_d = (i_q == I_LAST) ? DONE : READ_I;
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index, key and swap-operand registers advance alongside the state register.
  always_ff @(posedge clk or negedge master_reset) begin
    if (!master_reset) begin
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      s_i_q <= '0;
      s_j_q <= '0;
      key_r <= '0;
      lat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            key_r <= bus.secret_key;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            lat_q <= '0;
          end
        end
        WAIT_I: begin
          if (lat_last) begin
            s_i_q <= bus.q;
            j_q   <= j_q + bus.q + key_byte;
            lat_q <= '0;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        WAIT_J: begin
          if (lat_last) begin
            s_j_q <= bus.q;
            lat_q <= '0;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        NEXT: begin
          if (i_q != I_LAST) begin
            i_q <= i_q + ADDR_W'(1);
            k_q <= (k_q == K_LAST) ? '0 : k_q + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Self-checking bench: two DUTs (read latency 1 and 2) on behavioural S RAMs vs a software KSA.
module tb_ksa_swap_fsm;
  import rc4_pkg::*;

  localparam bit SKIP =
`ifdef KSA_SKIP_SELF_SWAP_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic master_reset;
  logic pre;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ksa_swap_fsm_if #(.KEY_BYTES(3)) bus1 ();
  ksa_swap_fsm_if #(.KEY_BYTES(3)) bus2 ();

  ksa_swap_fsm #(.KEY_BYTES(3), .READ_LATENCY(1)) dut1 (
    .clk(clk), .master_reset(master_reset), .bus(bus1));
  ksa_swap_fsm #(.KEY_BYTES(3), .READ_LATENCY(2)) dut2 (
    .clk(clk), .master_reset(master_reset), .bus(bus2));

  // Behavioural S RAMs with write logs
  logic [7:0]  mem1 [256];
  logic [7:0]  mem2 [256];
  logic [7:0]  p2a;
  logic [15:0] wlog1 [$];
  logic [15:0] wlog2 [$];

  always @(posedge clk) begin
    if (pre) begin
      for (int n = 0; n < 256; n++) mem1[n] <= 8'(n);
      wlog1.delete();
    end else if (bus1.write_out) begin
      mem1[bus1.address_out] <= bus1.data_out;
      wlog1.push_back({bus1.address_out, bus1.data_out});
    end
    bus1.q <= mem1[bus1.address_out];
  end

  always @(posedge clk) begin
    if (pre) begin
      for (int n = 0; n < 256; n++) mem2[n] <= 8'(n);
      wlog2.delete();
    end else if (bus2.write_out) begin
      mem2[bus2.address_out] <= bus2.data_out;
      wlog2.push_back({bus2.address_out, bus2.data_out});
    end
    p2a    <= mem2[bus2.address_out];
    bus2.q <= p2a;
  end

  // Golden software KSA
  logic [7:0]  gs [256];
  logic [15:0] ew [$];
  int          ew_iter [$];
  int          nself;

  task automatic golden(input logic [23:0] key);
    int j, kb;
    logic [7:0] t;
    j = 0;
    nself = 0;
    ew.delete();
    ew_iter.delete();
    for (int n = 0; n < 256; n++) gs[n] = 8'(n);
    for (int i = 0; i < 256; i++) begin
      kb = int'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = (j + int'(gs[i]) + kb) % 256;
      if (i == j) nself++;
      if (!(SKIP && i == j)) begin
        ew.push_back({8'(i), gs[j]});
        ew_iter.push_back(i);
        ew.push_back({8'(j), gs[i]});
        ew_iter.push_back(i);
      end
      t = gs[i]; gs[i] = gs[j]; gs[j] = t;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic drive(input int w, input logic s, input logic [23:0] k);
    if (w == 1) begin bus1.start = s; bus1.secret_key = k; end
    else        begin bus2.start = s; bus2.secret_key = k; end
  endtask

  function automatic logic get_done(input int w);
    return (w == 1) ? bus1.done : bus2.done;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 1) ? bus1.busy : bus2.busy;
  endfunction
  function automatic int wsize(input int w);
    return (w == 1) ? wlog1.size() : wlog2.size();
  endfunction
  function automatic logic [15:0] wget(input int w, input int idx);
    return (w == 1) ? wlog1[idx] : wlog2[idx];
  endfunction

  function automatic int s_mism(input int w);
    int m = 0;
    for (int n = 0; n < 256; n++)
      if (((w == 1) ? mem1[n] : mem2[n]) != gs[n]) m++;
    return m;
  endfunction

  function automatic int w_mism(input int w);
    int m = 0;
    int lim = (wsize(w) < ew.size()) ? wsize(w) : ew.size();
    for (int n = 0; n < lim; n++)
      if (wget(w, n) != ew[n]) m++;
    return m;
  endfunction

  task automatic do_reset();
    master_reset = 1'b0;
    drive(1, 1'b0, 24'h0);
    drive(2, 1'b0, 24'h0);
    @(negedge clk) pre = 1'b1;
    @(negedge clk) pre = 1'b0;
    master_reset = 1'b1;
  endtask

  task automatic run(input string tag, input int w, input logic [23:0] key, input int lat,
                     input bit hold, input logic [23:0] alt);
    int n, exp_lat;
    golden(key);
    exp_lat = 256 * (5 + 2 * lat) - (SKIP ? 2 * nself : 0);
    @(negedge clk) drive(w, 1'b1, key);
    @(posedge clk); #1;
    check({tag, "_busy_go"}, int'(get_busy(w)), 1);
    if (!hold) drive(w, 1'b0, key);
    n = 0;
    while (n < 4000 && !get_done(w)) begin
      @(posedge clk); #1;
      n++;
      if (n == 500) drive(w, hold, alt);
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_end"}, int'(get_busy(w)), 0);
    check({tag, "_final_s"}, s_mism(w), 0);
    check({tag, "_wcount"}, wsize(w), ew.size());
    check({tag, "_wseq"}, w_mism(w), 0);
  endtask

  initial begin
    logic [23:0] k3, kr;
    int idx, n, first;
    bit found;
    pre = 1'b0;
    drive(1, 1'b0, 24'h0);
    drive(2, 1'b0, 24'h0);
    master_reset = 1'b1;
    #1 master_reset = 1'b0;
    #1;
    check("rst_write", int'(bus1.write_out), 0);
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_addr", int'(bus1.address_out), 0);
    check("rst_data", int'(bus1.data_out), 0);
    check("rst_done2", int'(bus2.done), 0);

    // 1: all-zero key
    do_reset();
    run("t1", 1, 24'h000000, 1, 1'b0, 24'h000000);
    check("t1_w0", int'(wlog1[0]), SKIP ? 16'h0203 : 16'h0000);
    check("t1_w1", int'(wlog1[1]), SKIP ? 16'h0302 : 16'h0000);

    // 2: key 00033C, iteration 1 swaps s[1] and s[4]
    do_reset();
    run("t2", 1, 24'h00033C, 1, 1'b0, 24'h00033C);
    first = -1;
    for (int m = 0; m < wlog1.size(); m++)
      if (first < 0 && wlog1[m][15:8] == 8'h01) first = m;
    check("t2_found", int'(first >= 0 && first + 1 < wlog1.size()), 1);
    if (first >= 0 && first + 1 < wlog1.size()) begin
      check("t2_wr_i1", int'(wlog1[first]), 16'h0104);
      check("t2_wr_j4", int'(wlog1[first + 1]), 16'h0401);
    end

    // 3: reset during WRITE_I of iteration 100
    k3 = 24'h5A17C3;
    do_reset();
    golden(k3);
    idx = -1;
    for (int m = 0; m < ew_iter.size(); m++)
      if (idx < 0 && ew_iter[m] >= 100) idx = m;
    @(negedge clk) drive(1, 1'b1, k3);
    @(negedge clk) drive(1, 1'b0, k3);
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus1.write_out && wlog1.size() == idx) found = 1'b1;
    end
    check("t3_reached", int'(found), 1);
    master_reset = 1'b0;
    #1;
    check("t3_write", int'(bus1.write_out), 0);
    check("t3_done", int'(bus1.done), 0);
    check("t3_addr", int'(bus1.address_out), 0);
    check("t3_busy", int'(bus1.busy), 0);
    do_reset();
    run("t3", 1, k3, 1, 1'b0, k3);

    // 4: start held, key changed mid-run, done sticky
    do_reset();
    run("t4", 1, 24'hA5C301, 1, 1'b1, 24'hFFFFFF);
    repeat (40) @(posedge clk);
    #1;
    check("t4_done_sticky", int'(bus1.done), 1);
    check("t4_busy", int'(bus1.busy), 0);
    check("t4_no_restart", wlog1.size(), ew.size());
    check("t4_final_s", s_mism(1), 0);
    drive(1, 1'b0, 24'h0);

    // 5: read latency 2
    do_reset();
    run("t5", 2, 24'h00033C, 2, 1'b0, 24'h00033C);

    // random keys on both latencies
    for (int r = 0; r < 2; r++) begin
      kr = 24'($urandom());
      do_reset();
      run("rnd1", 1, kr, 1, 1'b0, kr);
      kr = 24'($urandom());
      do_reset();
      run("rnd2", 2, kr, 2, 1'b0, kr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
